// File: rtl/grill_lane_scheduler.sv
// Game-flow controller for three grill lanes: tick prescaler, wrapping lane scan,
// per-lane cook state machine, player request arbitration and score/burn accounting.
module grill_lane_scheduler #(
    parameter int TICK_DIV   = 25000000,
    parameter int COOK_TICKS = 6,
    parameter int BURN_TICKS = 3,
    parameter int MAX_BURNT  = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] place_req,
    input  logic [2:0] serve_req,
    output logic [5:0] lane_state,
    output logic [1:0] scan_lane,
    output logic       scan_valid,
    output logic [7:0] score,
    output logic [3:0] burnt_count,
    output logic       score_pulse,
    output logic       burnt_pulse,
    output logic       game_over
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    READY_AGE  = 4'(COOK_TICKS);
    localparam logic [3:0]    BURN_AGE   = 4'(COOK_TICKS + BURN_TICKS);
    localparam logic [3:0]    MAX_B      = 4'(MAX_BURNT);

    typedef enum logic [1:0] {
        TOP_IDLE      = 2'd0,
        TOP_RUN       = 2'd1,
        TOP_GAME_OVER = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        LANE_EMPTY   = 2'b00,
        LANE_COOKING = 2'b01,
        LANE_READY   = 2'b10,
        LANE_BURNT   = 2'b11
    } lane_t;

    top_state_t    top_state;
    logic [PW-1:0] presc;
    lane_t         lane_q [3];
    lane_t         lane_d [3];
    logic [3:0]    age_q  [3];
    logic [3:0]    age_d  [3];
    logic [2:0]    scored;
    logic [2:0]    burned;
    logic          tick;
    logic [1:0]    n_scored;
    logic [8:0]    score_sum;
    logic [7:0]    score_d;
    logic [3:0]    burnt_d;

    // scan_valid qualifies scan_lane; there is no back-pressure on the scan.
    assign tick       = (top_state == TOP_RUN) && (presc == PRESC_LAST);
    assign lane_state = {lane_q[2], lane_q[1], lane_q[0]};

    // Player requests take priority over the scan; a request on the scanned lane
    // drops that lane's age step for this sweep.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lane_d[i] = lane_q[i];
            age_d[i]  = age_q[i];
            scored[i] = 1'b0;
            burned[i] = 1'b0;
            if (serve_req[i]) begin
                if (lane_q[i] != LANE_EMPTY) begin
                    lane_d[i] = LANE_EMPTY;
                    age_d[i]  = 4'd0;
                    scored[i] = (lane_q[i] == LANE_READY);
                end
            end else if (place_req[i]) begin
                if (lane_q[i] == LANE_EMPTY) begin
                    lane_d[i] = LANE_COOKING;
                    age_d[i]  = 4'd0;
                end
            end else if (scan_valid && (scan_lane == 2'(i))) begin
                if (lane_q[i] == LANE_COOKING) begin
                    age_d[i] = age_q[i] + 4'd1;
                    if ((age_q[i] + 4'd1) == READY_AGE) begin
                        lane_d[i] = LANE_READY;
                    end
                end else if (lane_q[i] == LANE_READY) begin
                    age_d[i] = age_q[i] + 4'd1;
                    if ((age_q[i] + 4'd1) == BURN_AGE) begin
                        lane_d[i] = LANE_BURNT;
                        burned[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Several lanes may score together; the sum saturates at 255.
    always_comb begin
        n_scored  = 2'(scored[0]) + 2'(scored[1]) + 2'(scored[2]);
        score_sum = {1'b0, score} + {7'd0, n_scored};
        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
        burnt_d   = burnt_count;
        if ((|burned) && (burnt_count != 4'hF)) begin
            burnt_d = burnt_count + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            top_state   <= TOP_IDLE;
            presc       <= '0;
            scan_valid  <= 1'b0;
            scan_lane   <= 2'd0;
            score       <= 8'd0;
            burnt_count <= 4'd0;
            score_pulse <= 1'b0;
            burnt_pulse <= 1'b0;
            game_over   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                lane_q[i] <= LANE_EMPTY;
                age_q[i]  <= 4'd0;
            end
        end else begin
            score_pulse <= 1'b0;
            burnt_pulse <= 1'b0;
            case (top_state)
                TOP_RUN: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        scan_valid <= 1'b1;
                        scan_lane  <= 2'd0;
                    end else if (scan_valid) begin
                        if (scan_lane == 2'd2) begin
                            scan_valid <= 1'b0;
                            scan_lane  <= 2'd0;
                        end else begin
                            scan_lane <= scan_lane + 2'd1;
                        end
                    end
                    for (int i = 0; i < 3; i++) begin
                        lane_q[i] <= lane_d[i];
                        age_q[i]  <= age_d[i];
                    end
                    score       <= score_d;
                    burnt_count <= burnt_d;
                    score_pulse <= |scored;
                    burnt_pulse <= |burned;
                    // Game ends the cycle after the limiting burn is registered.
                    if (burnt_count == MAX_B) begin
                        top_state  <= TOP_GAME_OVER;
                        game_over  <= 1'b1;
                        scan_valid <= 1'b0;
                        scan_lane  <= 2'd0;
                    end
                end
                default: begin
                    if (start) begin
                        top_state   <= TOP_RUN;
                        game_over   <= 1'b0;
                        presc       <= '0;
                        scan_valid  <= 1'b0;
                        scan_lane   <= 2'd0;
                        score       <= 8'd0;
                        burnt_count <= 4'd0;
                        for (int i = 0; i < 3; i++) begin
                            lane_q[i] <= LANE_EMPTY;
                            age_q[i]  <= 4'd0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grill_lane_scheduler.sv
// Directed self-checking bench for grill_lane_scheduler with TICK_DIV=4, COOK_TICKS=6,
// BURN_TICKS=3, MAX_BURNT=3.
module tb_grill_lane_scheduler;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] place_req = 3'b000;
    logic [2:0] serve_req = 3'b000;
    logic [5:0] lane_state;
    logic [1:0] scan_lane;
    logic       scan_valid;
    logic [7:0] score;
    logic [3:0] burnt_count;
    logic       score_pulse;
    logic       burnt_pulse;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int exp_score = 0;

    grill_lane_scheduler #(
        .TICK_DIV  (4),
        .COOK_TICKS(6),
        .BURN_TICKS(3),
        .MAX_BURNT (3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .place_req  (place_req),
        .serve_req  (serve_req),
        .lane_state (lane_state),
        .scan_lane  (scan_lane),
        .scan_valid (scan_valid),
        .score      (score),
        .burnt_count(burnt_count),
        .score_pulse(score_pulse),
        .burnt_pulse(burnt_pulse),
        .game_over  (game_over)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lane_state"}, 32'(lane_state), 0);
        chk({tag, "_scan_lane"}, 32'(scan_lane), 0);
        chk({tag, "_scan_valid"}, 32'(scan_valid), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_burnt_count"}, 32'(burnt_count), 0);
        chk({tag, "_score_pulse"}, 32'(score_pulse), 0);
        chk({tag, "_burnt_pulse"}, 32'(burnt_pulse), 0);
        chk({tag, "_game_over"}, 32'(game_over), 0);
    endtask

    // Returns one cycle after start was sampled: RUN with prescaler at 0.
    task automatic reset_and_start();
        place_req = 3'b000;
        serve_req = 3'b000;
        start     = 1'b0;
        reset_n   = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic round(input logic [2:0] lanes);
        logic [5:0] pat;
        logic [5:0] mask;
        bit         ok;
        pat  = {(lanes[2] ? 2'b10 : 2'b00), (lanes[1] ? 2'b10 : 2'b00), (lanes[0] ? 2'b10 : 2'b00)};
        mask = {{2{lanes[2]}}, {2{lanes[1]}}, {2{lanes[0]}}};
        place_req = lanes;
        cyc(1);
        place_req = 3'b000;
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if ((lane_state & mask) == pat) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        chk("round_ready_wait", 32'(ok), 1);
        serve_req = lanes;
        cyc(1);
        serve_req = 3'b000;
        exp_score = exp_score + $countones(lanes);
        if (exp_score > 255) exp_score = 255;
        chk("round_score", 32'(score), 32'(exp_score));
        chk("round_score_pulse", 32'(score_pulse), 1);
        chk("round_lanes_empty", 32'(lane_state & mask), 0);
    endtask

    initial begin
        // Reset values and IDLE behaviour
        cyc(3);
        chk_zero("reset");
        reset_n = 1'b1;
        cyc(5);
        chk_zero("idle");
        place_req = 3'b001;
        cyc(1);
        place_req = 3'b000;
        chk("idle_place_ignored", 32'(lane_state), 0);

        // Start, first placement, first tick and scan
        reset_and_start();
        place_req = 3'b001;
        cyc(1);
        place_req = 3'b000;
        chk("start_place_lane0", 32'(lane_state), 32'(6'b000001));
        chk("pre_tick_valid_p2", 32'(scan_valid), 0);
        cyc(1);
        chk("pre_tick_valid_p3", 32'(scan_valid), 0);
        cyc(1);
        chk("pre_tick_valid_p4", 32'(scan_valid), 0);
        cyc(1);
        chk("scan0_valid", 32'(scan_valid), 1);
        chk("scan0_lane", 32'(scan_lane), 0);
        cyc(1);
        chk("scan1_valid", 32'(scan_valid), 1);
        chk("scan1_lane", 32'(scan_lane), 1);
        cyc(1);
        chk("scan2_valid", 32'(scan_valid), 1);
        chk("scan2_lane", 32'(scan_lane), 2);
        cyc(1);
        chk("scan_end_valid", 32'(scan_valid), 0);
        chk("scan_end_lane", 32'(scan_lane), 0);
        chk("scan_end_state", 32'(lane_state), 32'(6'b000001));

        // Cook lane 1 to READY and serve it
        reset_and_start();
        place_req = 3'b010;
        cyc(1);
        place_req = 3'b000;
        chk("cook_placed", 32'(lane_state), 32'(6'b000100));
        cyc(24);
        chk("cook_after5", 32'(lane_state), 32'(6'b000100));
        cyc(1);
        chk("cook_ready", 32'(lane_state), 32'(6'b001000));
        serve_req = 3'b010;
        cyc(1);
        serve_req = 3'b000;
        chk("serve_empty", 32'(lane_state), 0);
        chk("serve_score", 32'(score), 1);
        chk("serve_pulse", 32'(score_pulse), 1);
        cyc(1);
        chk("serve_pulse_drop", 32'(score_pulse), 0);
        chk("serve_score_hold", 32'(score), 1);

        // Burn all three lanes, game over
        reset_and_start();
        place_req = 3'b111;
        cyc(1);
        place_req = 3'b000;
        chk("burn_placed", 32'(lane_state), 32'(6'b010101));
        cyc(35);
        chk("burn_all_ready", 32'(lane_state), 32'(6'b101010));
        chk("burn_count0", 32'(burnt_count), 0);
        cyc(1);
        chk("burn1_state", 32'(lane_state), 32'(6'b101011));
        chk("burn1_pulse", 32'(burnt_pulse), 1);
        chk("burn1_count", 32'(burnt_count), 1);
        cyc(1);
        chk("burn2_state", 32'(lane_state), 32'(6'b101111));
        chk("burn2_pulse", 32'(burnt_pulse), 1);
        chk("burn2_count", 32'(burnt_count), 2);
        cyc(1);
        chk("burn3_state", 32'(lane_state), 32'(6'b111111));
        chk("burn3_pulse", 32'(burnt_pulse), 1);
        chk("burn3_count", 32'(burnt_count), 3);
        chk("burn3_not_over_yet", 32'(game_over), 0);
        cyc(1);
        chk("game_over_rise", 32'(game_over), 1);
        chk("game_over_pulse_drop", 32'(burnt_pulse), 0);
        chk("game_over_count", 32'(burnt_count), 3);
        place_req = 3'b111;
        serve_req = 3'b111;
        cyc(1);
        place_req = 3'b000;
        serve_req = 3'b000;
        chk("game_over_req_ignored", 32'(lane_state), 32'(6'b111111));
        chk("game_over_score", 32'(score), 0);
        cyc(8);
        chk("game_over_scan_frozen", 32'(scan_valid), 0);
        chk("game_over_hold", 32'(game_over), 1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("restart_lanes", 32'(lane_state), 0);
        chk("restart_burnt", 32'(burnt_count), 0);
        chk("restart_game_over", 32'(game_over), 0);

        // Serve on the scanned lane at the last age before burning
        reset_and_start();
        place_req = 3'b100;
        cyc(1);
        place_req = 3'b000;
        cyc(37);
        chk("conflict_scan_valid", 32'(scan_valid), 1);
        chk("conflict_scan_lane", 32'(scan_lane), 2);
        chk("conflict_ready", 32'(lane_state), 32'(6'b100000));
        serve_req = 3'b100;
        cyc(1);
        serve_req = 3'b000;
        chk("conflict_empty", 32'(lane_state), 0);
        chk("conflict_score", 32'(score), 1);
        chk("conflict_score_pulse", 32'(score_pulse), 1);
        chk("conflict_no_burn_pulse", 32'(burnt_pulse), 0);
        chk("conflict_no_burn_count", 32'(burnt_count), 0);
        cyc(1);
        chk("conflict_no_burn_later", 32'(burnt_pulse), 0);
        place_req = 3'b001;
        serve_req = 3'b001;
        cyc(1);
        place_req = 3'b000;
        serve_req = 3'b000;
        chk("place_serve_empty", 32'(lane_state), 0);

        // Score accumulation and saturation
        reset_and_start();
        exp_score = 0;
        round(3'b001);
        for (int r = 0; r < 3; r++) round(3'b111);
        chk("score_at_10", 32'(score), 10);
        round(3'b111);
        chk("score_at_13", 32'(score), 13);
        for (int r = 0; r < 80; r++) round(3'b111);
        chk("score_at_253", 32'(score), 253);
        round(3'b111);
        chk("score_sat_triple", 32'(score), 255);
        round(3'b010);
        chk("score_sat_single", 32'(score), 255);
        chk("burn_free_saturation", 32'(burnt_count), 0);

        // Asynchronous reset in the middle of a sweep
        reset_and_start();
        place_req = 3'b111;
        cyc(1);
        place_req = 3'b000;
        cyc(3);
        chk("midsweep_valid", 32'(scan_valid), 1);
        chk("midsweep_lanes", 32'(lane_state), 32'(6'b010101));
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        cyc(2);
        reset_n = 1'b1;
        cyc(10);
        chk_zero("post_reset_idle");
        place_req = 3'b001;
        cyc(1);
        place_req = 3'b000;
        chk("post_reset_place_ignored", 32'(lane_state), 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        place_req = 3'b001;
        cyc(1);
        place_req = 3'b000;
        chk("post_reset_restart_place", 32'(lane_state), 32'(6'b000001));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grill_lane_scheduler.md
Name: grill_lane_scheduler

Overview:
- Game-flow controller for the three grill lanes (lane index 0..2, wrapping 2->0).
- Generates the game tick from the system clock and sweeps the three lanes once per tick with a wrapping scan pointer.
- Runs a per-lane cook state machine and arbitrates player place/serve requests against the scan.
- Produces score, burn count and game-over status for the display and audio logic.

Parameters:
- TICK_DIV, 25000000, clock cycles per game tick; must be >= 4.
- COOK_TICKS, 6, ticks from placement until the lane becomes READY.
- BURN_TICKS, 3, further ticks in READY until the lane becomes BURNT; COOK_TICKS+BURN_TICKS <= 15.
- MAX_BURNT, 3, burn count that ends the game; 1..15.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset
- start  in  1  one-cycle pulse; begins a game from IDLE or GAME_OVER
- place_req  in  3  one-hot-per-lane pulses; player puts meat on lane i
- serve_req  in  3  pulses; player takes meat off lane i
- lane_state  out  6  2 bits per lane, lane i at [2i+1:2i]; 00 EMPTY, 01 COOKING, 10 READY, 11 BURNT
- scan_lane  out  2  scan pointer, values 0..2 only
- scan_valid  out  1  high during the 3 cycles the scan visits lanes
- score  out  8  served-ready count, saturates at 255
- burnt_count  out  4  burn events, saturates at 15
- score_pulse  out  1  one cycle on each scoring serve
- burnt_pulse  out  1  one cycle when any lane enters BURNT
- game_over  out  1  high in GAME_OVER state

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clock.
- Reset values: all outputs 0, all lanes EMPTY, all ages 0, prescaler 0, scan pointer 0, FSM IDLE.
- Reset mid-operation: abandons everything immediately and returns to the reset values.
- Top FSM: IDLE -start-> RUN (clears lanes, ages, score, burnt_count, prescaler); RUN -> GAME_OVER in the cycle after burnt_count reaches MAX_BURNT; GAME_OVER -start-> RUN (same clears).
- In IDLE and GAME_OVER: prescaler, scan and requests are frozen or ignored; lane_state, score and burnt_count hold.
- Prescaler: counts 0..TICK_DIV-1 in RUN only, then wraps; an internal tick is asserted in the cycle the count equals TICK_DIV-1.
- Scan: the cycle after tick, scan_valid=1 for exactly 3 cycles with scan_lane=0,1,2. scan_lane then returns to 0 and scan_valid=0.
- Scan never overlaps the next tick, since TICK_DIV >= 4.
- Per-lane update on its scan cycle:
  - COOKING: age+1; if the new age equals COOK_TICKS -> READY.
  - READY: age+1; if the new age equals COOK_TICKS+BURN_TICKS -> BURNT, burnt_pulse=1, burnt_count+1 (saturating).
  - EMPTY and BURNT: no change.
- Player requests (RUN only, evaluated every cycle, all lanes in parallel):
  - place_req[i] on EMPTY -> COOKING, age=0. place on any other state is ignored.
  - serve_req[i] on READY -> EMPTY, score+1 (saturating at 255), score_pulse=1.
  - serve on COOKING -> EMPTY, no score (undercooked).
  - serve on BURNT -> EMPTY (clear), no score.
  - serve on EMPTY is ignored.
  - place and serve on the same lane in the same cycle: serve wins, place ignored.
- Same-cycle conflict: a player request on lane i in the same cycle the scan visits lane i wins, and that lane's age update is dropped for this sweep.
- Multiple lanes: several lanes may score in one cycle. score adds the number of scoring serves (0..3) with saturation; score_pulse is still a single-cycle 1.
- Burn accounting: at most one burn per cycle, because the scan visits one lane per cycle.
- Game over: all output registers update on the clock edge. game_over rises the cycle after burnt_count==MAX_BURNT is registered. The burning lane stays BURNT.

Test Plan:
- Reset/start (TICK_DIV=4): hold reset_n=0 then release; all outputs 0. Pulse start, place_req=001. Next cycle lane_state=000001; first tick lands 4 cycles after start; scan_lane runs 0,1,2 with scan_valid high 3 cycles.
- Cook to serve (COOK_TICKS=6): place lane 1; after 6 sweeps lane_state[3:2]=10. serve_req=010 gives lane EMPTY, score=1, score_pulse for one cycle.
- Burn and game over (MAX_BURNT=3, BURN_TICKS=3): place lanes 0,1,2 and never serve. After 9 sweeps all are BURNT, burnt_pulse fires 3 times on consecutive scan cycles, burnt_count=3. game_over=1 next cycle; further place_req is ignored.
- Conflict: serve_req on lane 2 in the exact cycle scan_lane=2 while READY at age COOK_TICKS+BURN_TICKS-1 gives EMPTY and score+1, with no burnt_pulse. Place+serve on EMPTY lane 0 in the same cycle leaves it EMPTY.
- Saturation: preload via 255 scoring serves; one more scoring serve leaves score=255 with score_pulse still 1. Three lanes served READY simultaneously at score=10 gives 13.
- Async reset mid-sweep: drop reset_n while scan_valid=1 and lanes COOKING. Outputs are 0 before the next clock edge; after release the FSM stays IDLE until start.
